// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// RV64 func3 size/sign codes, FSM state encoding, byte-strobe width and size decode.
package dmem_pkg;

    localparam int STRB_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Access size in bytes (1/2/4/8); bit 2 of func3 only selects zero-extension.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Bus bundles for the access unit: pipeline request/response side and
// word-aligned memory port. The unit is the slave of the request bus and
// the master of the memory bus.
interface dmem_req_if #(parameter int ADDR_W = 64);
    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [2:0]        req_func3;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (output req_valid, req_rw, req_addr, req_wdata, req_func3,
                    input  req_ready, stall, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_rw, req_addr, req_wdata, req_func3,
                    output req_ready, stall, resp_valid, resp_rdata, resp_err);
endinterface

interface dmem_mem_if #(parameter int ADDR_W = 64);
    import dmem_pkg::*;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [63:0]       mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/dmem_access_unit_lane_align.sv
// Combinational byte-lane logic: store data/strobe shift for the incoming
// request and load extract + sign/zero extension for the returning data.
// DMEM_MISALIGN_TRAP_EN: when defined, an address not aligned to the access
// size is reported as a fault; otherwise the low bits are silently cleared.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        i_f3,
    input  logic [2:0]        i_addr_lo,
    input  logic [63:0]       i_wdata,
    output logic [2:0]        o_lane,
    output logic              o_fault,
    output logic [63:0]       o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    input  logic [2:0]        i_ld_f3,
    input  logic [2:0]        i_ld_lane,
    input  logic [63:0]       i_rdata,
    output logic [63:0]       o_rdata
);
    logic [3:0]        w_sz;
    logic [2:0]        w_amask;
    logic [STRB_W-1:0] w_bmask;
    logic [63:0]       w_rsh;
    logic              w_sgn;

    assign w_sz    = size_bytes(i_f3);
    assign w_amask = 3'(w_sz - 4'd1);
    assign w_bmask = 8'((9'd1 << w_sz) - 9'd1);
    assign o_lane  = i_addr_lo & ~w_amask;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign o_fault = |(i_addr_lo & w_amask);
`else
    assign o_fault = 1'b0;
`endif

    assign o_wstrb = w_bmask << o_lane;
    assign o_wdata = i_wdata << {o_lane, 3'b000};

    assign w_rsh = i_rdata >> {i_ld_lane, 3'b000};
    assign w_sgn = ~i_ld_f3[2];

    // Truncate the lane-shifted read word to the access size and extend.
    always_comb begin
        o_rdata = w_rsh;
        case (i_ld_f3[1:0])
            2'b00:   o_rdata = {{56{w_sgn & w_rsh[7]}},  w_rsh[7:0]};
            2'b01:   o_rdata = {{48{w_sgn & w_rsh[15]}}, w_rsh[15:0]};
            2'b10:   o_rdata = {{32{w_sgn & w_rsh[31]}}, w_rsh[31:0]};
            default: o_rdata = w_rsh;
        endcase
    end
endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: one load/store at a time, IDLE->BUSY->DONE,
// stalls the pipeline until the memory acks or the wait times out.
// DMEM_MISALIGN_TRAP_EN (see dmem_lane_align) turns misaligned accesses into faults.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
)(
    input  logic          i_clk,
    input  logic          i_rst,
    dmem_req_if.slave     io_req,
    dmem_mem_if.master    io_mem
);
    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN   = (TIMEOUT != 0);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_lane;
    logic [2:0]        r_f3;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic [2:0]        w_lane;
    logic              w_misalign;
    logic [63:0]       w_wdata_sh;
    logic [STRB_W-1:0] w_wstrb;
    logic [63:0]       w_ld_data;
    logic              w_illegal;
    logic              w_fault;
    logic              w_expire;

    dmem_lane_align u_align (
        .i_f3      (io_req.req_func3),
        .i_addr_lo (io_req.req_addr[2:0]),
        .i_wdata   (io_req.req_wdata),
        .o_lane    (w_lane),
        .o_fault   (w_misalign),
        .o_wdata   (w_wdata_sh),
        .o_wstrb   (w_wstrb),
        .i_ld_f3   (r_f3),
        .i_ld_lane (r_lane),
        .i_rdata   (io_mem.mem_rdata),
        .o_rdata   (w_ld_data)
    );

    // Stores only go up to sd; loads allow everything but 3'b111.
    assign w_illegal = io_req.req_rw ? (io_req.req_func3 > F3_D) : (io_req.req_func3 > F3_WU);
    assign w_fault   = w_illegal | w_misalign;
    assign w_expire  = TO_EN && (r_cnt == CNT_MAX);

    assign io_req.req_ready  = io_req.req_valid & (r_state == IDLE);
    assign io_req.stall      = ((r_state == IDLE) & io_req.req_valid) | (r_state == BUSY);
    assign io_req.resp_valid = (r_state == DONE);
    assign io_req.resp_rdata = r_rdata;
    assign io_req.resp_err   = r_err;

    assign io_mem.mem_req   = r_mem_req;
    assign io_mem.mem_we    = r_mem_we;
    assign io_mem.mem_addr  = r_mem_addr;
    assign io_mem.mem_wdata = r_mem_wdata;
    assign io_mem.mem_wstrb = r_mem_wstrb;

    // Access FSM: accept, hold the memory request until ack/timeout, pulse the response.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lane      <= '0;
            r_f3        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (io_req.req_valid) begin
                    r_cnt   <= '0;
                    r_lane  <= w_lane;
                    r_f3    <= io_req.req_func3;
                    r_rdata <= '0;
                    if (w_fault) begin
                        r_state <= DONE;
                        r_err   <= 1'b1;
                    end else begin
                        r_state     <= BUSY;
                        r_err       <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= io_req.req_rw;
                        r_mem_addr  <= {io_req.req_addr[ADDR_W-1:3], 3'b000};
                        r_mem_wdata <= io_req.req_rw ? w_wdata_sh : 64'd0;
                        r_mem_wstrb <= io_req.req_rw ? w_wstrb : '0;
                    end
                end
                BUSY: begin
                    // Ack takes priority over an expiry in the same cycle.
                    if (io_mem.mem_ack || w_expire) begin
                        r_state     <= DONE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= '0;
                        if (io_mem.mem_ack) begin
                            if (!r_mem_we)
                                r_rdata <= w_ld_data;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit (TIMEOUT=4) with a simple acking memory.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    dmem_req_if #(.ADDR_W(ADDR_W)) req_bus ();
    dmem_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

    dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_req (req_bus),
        .io_mem (mem_bus)
    );

    always #5 clk = ~clk;

    // Observations from the last transaction.
    int          t_vcyc;
    int          t_reqn;
    logic [63:0] t_rdata;
    logic        t_err;
    logic        t_stall_done;
    logic        t_we;
    logic [63:0] t_addr;
    logic [63:0] t_wdata;
    logic [7:0]  t_wstrb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at cycle 0; ack at cycle k (k=0: never ack).
    task automatic txn(input logic rw, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [2:0] f3, input int k, input logic [63:0] rd);
        int cyc;
        @(negedge clk);
        req_bus.req_valid = 1'b1;
        req_bus.req_rw    = rw;
        req_bus.req_addr  = addr;
        req_bus.req_wdata = wd;
        req_bus.req_func3 = f3;
        mem_bus.mem_rdata = rd;
        #1;
        check("stall_on_req", 64'(req_bus.stall), 64'd1);
        check("ready_on_req", 64'(req_bus.req_ready), 64'd1);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        cyc    = 1;
        t_vcyc = -1;
        t_reqn = 0;
        t_rdata = 'x;
        t_err   = 1'bx;
        t_stall_done = 1'bx;
        while (cyc < 40 && t_vcyc < 0) begin
            mem_bus.mem_ack = (k != 0 && cyc == k);
            #1;
            if (cyc == 1) begin
                t_we    = mem_bus.mem_we;
                t_addr  = mem_bus.mem_addr;
                t_wdata = mem_bus.mem_wdata;
                t_wstrb = mem_bus.mem_wstrb;
            end
            if (mem_bus.mem_req) t_reqn++;
            if (req_bus.resp_valid) begin
                t_vcyc       = cyc;
                t_rdata      = req_bus.resp_rdata;
                t_err        = req_bus.resp_err;
                t_stall_done = req_bus.stall;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        req_bus.req_valid = 1'b0;
        req_bus.req_rw    = 1'b0;
        req_bus.req_addr  = '0;
        req_bus.req_wdata = '0;
        req_bus.req_func3 = '0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_ack   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req",    64'(mem_bus.mem_req),    64'd0);
        check("rst_stall",      64'(req_bus.stall),      64'd0);
        check("rst_resp_valid", 64'(req_bus.resp_valid), 64'd0);
        check("rst_resp_err",   64'(req_bus.resp_err),   64'd0);
        check("rst_ready",      64'(req_bus.req_ready),  64'd0);
        check("rst_wstrb",      64'(mem_bus.mem_wstrb),  64'd0);
        check("rst_rdata",      req_bus.resp_rdata,      64'd0);
        rst = 1'b1;

        // ld, ack 3 cycles after accept
        txn(1'b0, 64'h1008, 64'd0, F3_D, 3, 64'h8877665544332211);
        check("ld_addr",  t_addr, 64'h1008);
        check("ld_we",    64'(t_we), 64'd0);
        check("ld_wstrb", 64'(t_wstrb), 64'd0);
        check("ld_vcyc",  64'(t_vcyc), 64'd4);
        check("ld_rdata", t_rdata, 64'h8877665544332211);
        check("ld_err",   64'(t_err), 64'd0);
        check("ld_reqn",  64'(t_reqn), 64'd3);
        check("ld_stall_done", 64'(t_stall_done), 64'd0);

        // sb at byte 3, minimum latency
        txn(1'b1, 64'h2003, 64'hAB, F3_B, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sb_addr",  t_addr, 64'h2000);
        check("sb_we",    64'(t_we), 64'd1);
        check("sb_wstrb", 64'(t_wstrb), 64'h08);
        check("sb_wdata", t_wdata, 64'h0000_0000_AB00_0000);
        check("sb_vcyc",  64'(t_vcyc), 64'd2);
        check("sb_err",   64'(t_err), 64'd0);
        check("sb_rdata", t_rdata, 64'd0);

        // lb / lbu of byte 5 = 0x80
        txn(1'b0, 64'h5, 64'd0, F3_B, 1, 64'h0000_8000_0000_0000);
        check("lb_rdata", t_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        txn(1'b0, 64'h5, 64'd0, F3_BU, 2, 64'h0000_8000_0000_0000);
        check("lbu_rdata", t_rdata, 64'h80);
        check("lbu_vcyc",  64'(t_vcyc), 64'd3);

        // lh / lw / lwu sign and zero extension
        txn(1'b0, 64'h2, 64'd0, F3_H, 1, 64'h0000_0000_F00D_0000);
        check("lh_rdata", t_rdata, 64'hFFFF_FFFF_FFFF_F00D);
        txn(1'b0, 64'h4, 64'd0, F3_W, 1, 64'h89AB_CDEF_0000_0000);
        check("lw_rdata", t_rdata, 64'hFFFF_FFFF_89AB_CDEF);
        txn(1'b0, 64'h4, 64'd0, F3_WU, 1, 64'h89AB_CDEF_0000_0000);
        check("lwu_rdata", t_rdata, 64'h0000_0000_89AB_CDEF);

        // Misaligned word access at 0x6
        txn(1'b1, 64'h6, 64'h1122_3344, F3_W, 1, 64'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_sw_reqn", 64'(t_reqn), 64'd0);
        check("mis_sw_err",  64'(t_err), 64'd1);
        check("mis_sw_vcyc", 64'(t_vcyc), 64'd1);
`else
        check("mis_sw_addr",  t_addr, 64'h0);
        check("mis_sw_wstrb", 64'(t_wstrb), 64'hF0);
        check("mis_sw_wdata", t_wdata, 64'h1122_3344_0000_0000);
        check("mis_sw_err",   64'(t_err), 64'd0);
`endif
        txn(1'b0, 64'h6, 64'd0, F3_W, 1, 64'h89AB_CDEF_0000_0000);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_lw_err",   64'(t_err), 64'd1);
        check("mis_lw_rdata", t_rdata, 64'd0);
`else
        check("mis_lw_rdata", t_rdata, 64'hFFFF_FFFF_89AB_CDEF);
        check("mis_lw_err",   64'(t_err), 64'd0);
`endif

        // sd with ack on the same cycle the timeout would expire
        txn(1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, F3_D, 4, 64'd0);
        check("sd_wstrb", 64'(t_wstrb), 64'hFF);
        check("sd_wdata", t_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("sd_vcyc",  64'(t_vcyc), 64'd5);
        check("sd_err",   64'(t_err), 64'd0);

        // Timeout: never acked
        txn(1'b0, 64'h20, 64'd0, F3_D, 0, 64'h1234);
        check("to_reqn",  64'(t_reqn), 64'd4);
        check("to_vcyc",  64'(t_vcyc), 64'd5);
        check("to_err",   64'(t_err), 64'd1);
        check("to_rdata", t_rdata, 64'd0);

        // Late ack while idle is ignored
        @(negedge clk);
        mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        #1;
        check("late_ack_req",   64'(mem_bus.mem_req),    64'd0);
        check("late_ack_valid", 64'(req_bus.resp_valid), 64'd0);
        txn(1'b0, 64'h28, 64'd0, F3_D, 2, 64'h0102_0304_0506_0708);
        check("after_to_vcyc",  64'(t_vcyc), 64'd3);
        check("after_to_rdata", t_rdata, 64'h0102_0304_0506_0708);
        check("after_to_err",   64'(t_err), 64'd0);

        // Illegal func3
        txn(1'b0, 64'h30, 64'd0, 3'b111, 0, 64'd0);
        check("ill_ld_err",  64'(t_err), 64'd1);
        check("ill_ld_vcyc", 64'(t_vcyc), 64'd1);
        check("ill_ld_reqn", 64'(t_reqn), 64'd0);
        txn(1'b1, 64'h30, 64'h55, 3'b100, 0, 64'd0);
        check("ill_st_err",  64'(t_err), 64'd1);
        check("ill_st_reqn", 64'(t_reqn), 64'd0);

        // Reset while BUSY abandons the access
        @(negedge clk);
        req_bus.req_valid = 1'b1;
        req_bus.req_rw    = 1'b0;
        req_bus.req_addr  = 64'h40;
        req_bus.req_func3 = F3_D;
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        #1;
        check("busy_mem_req", 64'(mem_bus.mem_req), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy_mem_req", 64'(mem_bus.mem_req),    64'd0);
        check("rst_busy_stall",   64'(req_bus.stall),      64'd0);
        check("rst_busy_valid",   64'(req_bus.resp_valid), 64'd0);
        rst = 1'b1;
        txn(1'b0, 64'h48, 64'd0, F3_D, 1, 64'hCAFE);
        check("post_rst_vcyc",  64'(t_vcyc), 64'd2);
        check("post_rst_rdata", t_rdata, 64'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
